tx_cfg_ctrl: RTL and testbench
==============================

TX_CFG_CTRL -- requirements
Module: tx_cfg_ctrl

Interface
REQ-001 Parameter NTAPS, default 16: number of coefficients per RCF load.
REQ-002 Parameter FLUSH_CYC, default 64: number of cycles the transmit chain is held in reset after a load; legal range is 1..1023.
REQ-003 The clock and reset are fixed: one clock, clk_61p44MHz; reset is asynchronous and active-high.
REQ-004 Port list (name, direction, width, meaning):
- clk_61p44MHz, input, 1: sole clock; every register is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- cfg_start, input, 1: one-cycle pulse that begins a coefficient load.
- cfg_valid, input, 1: the host presents cfg_data.
- cfg_data, input, 16: signed coefficient word.
- cfg_ready, output, 1: the block accepts a word this cycle.
- rcf_we, output, 1: write strobe to the RCF coefficient port.
- rcf_coeff, output, 16: coefficient to the RCF.
- chain_rst, output, 1: active-high reset for the RCF/FIR/CIC/DDS/modulator chain.
- tx_en, output, 1: the chain is running and data is valid.
- busy, output, 1: the block is in LOAD or FLUSH.
- coeff_sum, output, 20: signed running sum of the coefficients in the current load.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, LOAD, FLUSH, RUN.
REQ-006 IDLE SHALL drive chain_rst=1, tx_en=0, cfg_ready=0, and SHALL go to LOAD on cfg_start.
REQ-007 On entry to LOAD, the block SHALL clear tap_cnt (log2(NTAPS)+1 bits) and coeff_sum to 0.
REQ-008 In LOAD, cfg_ready SHALL be 1 from the first LOAD cycle until the NTAPS-th transfer.
REQ-009 A transfer SHALL occur only on a cycle where cfg_valid=1 and cfg_ready=1 are both high.
REQ-010 The cycle after each transfer, rcf_we SHALL be 1 for exactly one cycle with rcf_coeff equal to the transferred cfg_data (latency 1).
REQ-011 rcf_coeff SHALL hold its last value while rcf_we=0.
REQ-012 On each transfer, tap_cnt SHALL increment and coeff_sum SHALL add the sign-extended cfg_data; the sum cannot overflow because 16 x 2^15 fits in 20 bits signed.
REQ-013 The cycle after the NTAPS-th transfer, cfg_ready SHALL be 0 and the FSM SHALL be in FLUSH; that cycle also carries the last rcf_we pulse.
REQ-014 Cycles with cfg_valid=0 in LOAD SHALL stall without timeout, and tap_cnt SHALL be unchanged.
REQ-015 FLUSH SHALL hold chain_rst=1 for exactly FLUSH_CYC cycles, counted from the first FLUSH cycle, then enter RUN.
REQ-016 RUN SHALL drive chain_rst=0 and tx_en=1, both registered and changing on the same edge.
REQ-017 cfg_start in RUN SHALL enter LOAD on the next edge, with chain_rst=1 and tx_en=0 from that edge.
REQ-018 cfg_start in LOAD or FLUSH SHALL restart LOAD: tap_cnt=0, coeff_sum=0, flush counter cleared.
REQ-019 A transfer coincident with cfg_start SHALL be discarded: no rcf_we pulse, and it is not counted.
REQ-020 busy SHALL equal 1 exactly when the state is LOAD or FLUSH.
REQ-021 coeff_sum SHALL hold its value in FLUSH, RUN and IDLE until the next LOAD entry.
REQ-022 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-023 While reset=1, the state SHALL be IDLE.
REQ-024 While reset=1, the outputs SHALL be: chain_rst=1, tx_en=0, cfg_ready=0, rcf_we=0, rcf_coeff=0, busy=0, coeff_sum=0, and all counters 0.
REQ-025 These reset values SHALL take effect asynchronously on assertion of reset, independent of the clock.
REQ-026 Reset asserted mid-LOAD or mid-FLUSH SHALL abandon the operation; after release, the block SHALL stay in IDLE until cfg_start.

Verification
REQ-027 Nominal load:
- Stimulus: cfg_start, then 16 back-to-back words 1..16.
- Response: 16 rcf_we pulses each one cycle after its transfer, rcf_coeff=1..16, coeff_sum=136.
- Then: FLUSH 64 cycles, then tx_en=1 and chain_rst=0.
REQ-028 Gapped load:
- Stimulus: cfg_valid toggled every other cycle, words alternating -32768 and 32767.
- Response: exactly 16 we pulses, coeff_sum=-8, no extra pulse once cfg_ready drops.
REQ-029 Restart in LOAD:
- Stimulus: cfg_start after 5 transfers, with cfg_valid high in that same cycle.
- Response: that word produces no rcf_we pulse, tap_cnt=0, coeff_sum=0, and the next 16 words complete the load normally.
REQ-030 Reload from RUN:
- Stimulus: cfg_start while tx_en=1.
- Response: next edge gives tx_en=0, chain_rst=1, busy=1, cfg_ready=1.
REQ-031 Async reset mid-FLUSH:
- Stimulus: assert reset between clock edges at flush cycle 30.
- Response: immediately chain_rst=1, busy=0, coeff_sum=0; after release the block stays IDLE for 100 cycles with cfg_valid=1.

Source files
------------

// File: rtl/tx_cfg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tx_cfg_ctrl                                                   |
// | Purpose  : Loads RCF coefficients from a host, then flushes and releases |
// |            the transmit chain.                                           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tx_cfg_ctrl #(
    parameter int NTAPS     = 16,
    parameter int FLUSH_CYC = 64
) (
    input  logic        clk_61p44MHz,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic        cfg_valid,
    input  logic [15:0] cfg_data,
    output logic        cfg_ready,
    output logic        rcf_we,
    output logic [15:0] rcf_coeff,
    output logic        chain_rst,
    output logic        tx_en,
    output logic        busy,
    output logic [19:0] coeff_sum
);

    localparam int               TAP_W      = $clog2(NTAPS) + 1;
    localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(NTAPS - 1);
    localparam logic [9:0]       FLUSH_LAST = 10'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t           state_q;
    logic [TAP_W-1:0] tap_cnt_q;
    logic [9:0]       flush_cnt_q;
    logic             cfg_ready_q;
    logic             rcf_we_q;
    logic [15:0]      rcf_coeff_q;
    logic             chain_rst_q;
    logic             tx_en_q;
    logic             busy_q;
    logic [19:0]      coeff_sum_q;
    logic [19:0]      coeff_sum_d;

    assign coeff_sum_d = coeff_sum_q + {{4{cfg_data[15]}}, cfg_data};

    always_ff @(posedge clk_61p44MHz or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tap_cnt_q   <= '0;
            flush_cnt_q <= '0;
            cfg_ready_q <= 1'b0;
            rcf_we_q    <= 1'b0;
            rcf_coeff_q <= '0;
            chain_rst_q <= 1'b1;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            coeff_sum_q <= '0;
        end else begin
            rcf_we_q <= 1'b0;
            // A start pulse wins over everything, including a word presented in the same cycle.
            if (cfg_start) begin
                state_q     <= ST_LOAD;
                tap_cnt_q   <= '0;
                flush_cnt_q <= '0;
                coeff_sum_q <= '0;
                cfg_ready_q <= 1'b1;
                busy_q      <= 1'b1;
                chain_rst_q <= 1'b1;
                tx_en_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        chain_rst_q <= 1'b1;
                        tx_en_q     <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                    ST_LOAD: begin
                        if (cfg_valid && cfg_ready_q) begin
                            rcf_we_q    <= 1'b1;
                            rcf_coeff_q <= cfg_data;
                            tap_cnt_q   <= tap_cnt_q + TAP_W'(1);
                            coeff_sum_q <= coeff_sum_d;
                            if (tap_cnt_q == TAP_LAST) begin
                                state_q     <= ST_FLUSH;
                                cfg_ready_q <= 1'b0;
                                flush_cnt_q <= '0;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        // Counter value k marks flush cycle k+1, so the last value ends the hold.
                        if (flush_cnt_q == FLUSH_LAST) begin
                            state_q     <= ST_RUN;
                            chain_rst_q <= 1'b0;
                            tx_en_q     <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + 10'd1;
                        end
                    end
                    ST_RUN: begin
                        chain_rst_q <= 1'b0;
                        tx_en_q     <= 1'b1;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        chain_rst_q <= 1'b1;
                        tx_en_q     <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign rcf_we    = rcf_we_q;
    assign rcf_coeff = rcf_coeff_q;
    assign chain_rst = chain_rst_q;
    assign tx_en     = tx_en_q;
    assign busy      = busy_q;
    assign coeff_sum = coeff_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_cfg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tx_cfg_ctrl                                                |
// | Purpose  : Directed self-checking bench for tx_cfg_ctrl.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_tx_cfg_ctrl;

    localparam int NTAPS     = 16;
    localparam int FLUSH_CYC = 64;

    logic        clk;
    logic        reset;
    logic        cfg_start;
    logic        cfg_valid;
    logic [15:0] cfg_data;
    logic        cfg_ready;
    logic        rcf_we;
    logic [15:0] rcf_coeff;
    logic        chain_rst;
    logic        tx_en;
    logic        busy;
    logic [19:0] coeff_sum;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;
    exp_t q[$];

    tx_cfg_ctrl #(.NTAPS(NTAPS), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk_61p44MHz (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .rcf_we       (rcf_we),
        .rcf_coeff    (rcf_coeff),
        .chain_rst    (chain_rst),
        .tx_en        (tx_en),
        .busy         (busy),
        .coeff_sum    (coeff_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard drain: every write strobe must match the oldest accepted word, one cycle later.
    always @(negedge clk) begin
        if (rcf_we === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rcf_coeff", 32'(rcf_coeff), 32'(e.d));
                chk("we_latency", 32'(cyc), 32'(e.c + 1));
            end
        end
    end

    task automatic start_load();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("load_ready", 32'(cfg_ready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_chain_rst", 32'(chain_rst), 32'd1);
        chk("load_tx_en", 32'(tx_en), 32'd0);
        chk("load_sum_clr", 32'(coeff_sum), 32'd0);
    endtask

    task automatic send_word(input logic [15:0] d);
        exp_t e;
        chk("ready_at_send", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_data  = d;
        e.d = d;
        e.c = cyc;
        q.push_back(e);
        step();
    endtask

    task automatic wait_run();
        int n = 0;
        while (tx_en !== 1'b1 && n < FLUSH_CYC + 10) begin
            step();
            n++;
        end
        chk("run_reached", 32'(tx_en), 32'd1);
        chk("run_chain_rst", 32'(chain_rst), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        repeat (3) step();
        chk("rst_chain_rst", 32'(chain_rst), 32'd1);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_we", 32'(rcf_we), 32'd0);
        chk("rst_coeff", 32'(rcf_coeff), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(coeff_sum), 32'd0);
        reset = 1'b0;
        repeat (3) step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_chain_rst", 32'(chain_rst), 32'd1);
        chk("idle_ready", 32'(cfg_ready), 32'd0);

        // Nominal load 1..16, then exact flush length.
        start_load();
        for (int i = 1; i <= NTAPS; i++) send_word(16'(i));
        cfg_valid = 1'b0;
        chk("nom_ready_drop", 32'(cfg_ready), 32'd0);
        chk("nom_flush_busy", 32'(busy), 32'd1);
        chk("nom_sum", 32'(coeff_sum), 32'(20'd136));
        repeat (FLUSH_CYC - 1) step();
        chk("nom_flush_last_rst", 32'(chain_rst), 32'd1);
        chk("nom_flush_last_tx", 32'(tx_en), 32'd0);
        step();
        chk("nom_run_tx_en", 32'(tx_en), 32'd1);
        chk("nom_run_chain_rst", 32'(chain_rst), 32'd0);
        chk("nom_run_busy", 32'(busy), 32'd0);
        chk("nom_coeff_hold", 32'(rcf_coeff), 32'd16);
        chk("nom_sum_hold", 32'(coeff_sum), 32'(20'd136));
        chk("nom_q_empty", 32'(q.size()), 32'd0);

        // Reload from RUN, gapped extreme words, extra valids after ready drops.
        start_load();
        for (int i = 0; i < NTAPS; i++) begin
            send_word((i % 2 == 0) ? 16'h8000 : 16'h7FFF);
            cfg_valid = 1'b0;
            cfg_data  = 16'hAAAA;
            step();
        end
        chk("gap_ready_drop", 32'(cfg_ready), 32'd0);
        chk("gap_sum", 32'(coeff_sum), 32'(20'hFFFF8));
        cfg_valid = 1'b1;
        cfg_data  = 16'h1234;
        repeat (4) step();
        cfg_valid = 1'b0;
        wait_run();
        chk("gap_q_empty", 32'(q.size()), 32'd0);
        chk("gap_sum_hold", 32'(coeff_sum), 32'(20'hFFFF8));

        // Restart in LOAD with a coincident word that must be dropped.
        start_load();
        for (int i = 10; i < 15; i++) send_word(16'(i));
        cfg_valid = 1'b1;
        cfg_data  = 16'h7777;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("rst_load_sum", 32'(coeff_sum), 32'd0);
        chk("rst_load_ready", 32'(cfg_ready), 32'd1);
        chk("rst_load_busy", 32'(busy), 32'd1);
        chk("rst_load_q", 32'(q.size()), 32'd0);
        for (int i = 100; i < 100 + NTAPS; i++) send_word(16'(i));
        cfg_valid = 1'b0;
        chk("rst_load_ready_drop", 32'(cfg_ready), 32'd0);
        chk("rst_load_final_sum", 32'(coeff_sum), 32'(20'd1720));
        wait_run();
        chk("rst_load_q_empty", 32'(q.size()), 32'd0);

        // Async reset at flush cycle 30, between clock edges.
        start_load();
        for (int i = 0; i < NTAPS; i++) send_word(16'hFFFF);
        cfg_valid = 1'b0;
        chk("ar_sum", 32'(coeff_sum), 32'(20'hFFFF0));
        repeat (29) step();
        chk("ar_in_flush", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_chain_rst", 32'(chain_rst), 32'd1);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_sum_clr", 32'(coeff_sum), 32'd0);
        chk("ar_tx_en", 32'(tx_en), 32'd0);
        chk("ar_ready", 32'(cfg_ready), 32'd0);
        chk("ar_coeff", 32'(rcf_coeff), 32'd0);
        step();
        reset     = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 16'h0005;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("ar_stay_idle", 32'({busy, cfg_ready, chain_rst, tx_en}), 32'(4'b0010));
        end
        cfg_valid = 1'b0;
        chk("ar_q_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
